// File: rtl/usr_serdes_ctrl.sv
// usr_serdes_ctrl: word-level serialiser/deserialiser sequencer for one external
// 4-mode universal shift register (hold / right / left / load on usr_s).
// TX loads the word and shifts it out one bit per BIT_DIV cycles; RX clears the
// USR and shifts ser_in in, then captures usr_q into dout.
module usr_serdes_ctrl #(
  parameter int N       = 4,
  parameter int BIT_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic         dir,
  input  logic [N-1:0] din,
  input  logic         ser_in,
  input  logic [N-1:0] usr_q,
  output logic [1:0]   usr_s,
  output logic [N-1:0] usr_I,
  output logic         usr_msb_in,
  output logic         usr_lsb_in,
  output logic         ser_out,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] dout
);

  // A 1-bit divider counter is kept even when BIT_DIV is 1 so the logic stays uniform.
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BIT_W = $clog2(N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             mode_r, dir_r;
  logic [N-1:0]     word_r;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_nxt_s;
  logic [BIT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [N-1:0]     dout_r, dout_nxt_s;
  logic             accept_s;
  logic             wrap_s;

  assign accept_s = (state_r == ST_IDLE) && start;
  assign wrap_s   = (div_cnt_r == DIV_LAST);

  // State, counters and captured word; transaction parameters latch only on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      dout_r    <= {N{1'b0}};
      mode_r    <= 1'b0;
      dir_r     <= 1'b0;
      word_r    <= {N{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      dout_r    <= dout_nxt_s;
      if (accept_s) begin
        mode_r <= mode;
        dir_r  <= dir;
        word_r <= din;
      end else begin
        mode_r <= mode_r;
        dir_r  <= dir_r;
        word_r <= word_r;
      end
    end
  end

  // Next-state, counter update and USR control decode for the current state.
  always_comb begin
    state_nxt_s   = state_r;
    div_cnt_nxt_s = div_cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    dout_nxt_s    = dout_r;
    usr_s         = 2'b00;
    usr_I         = {N{1'b0}};
    ser_out       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        usr_s         = 2'b11;
        // RX starts from a cleared register so unfilled positions read as zero.
        usr_I         = mode_r ? {N{1'b0}} : word_r;
        div_cnt_nxt_s = {DIV_W{1'b0}};
        bit_cnt_nxt_s = {BIT_W{1'b0}};
        state_nxt_s   = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_out = mode_r ? 1'b0 : (dir_r ? usr_q[N-1] : usr_q[0]);
        if (wrap_s) begin
          usr_s         = dir_r ? 2'b10 : 2'b01;
          div_cnt_nxt_s = {DIV_W{1'b0}};
          bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
          state_nxt_s   = ST_SHIFT;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        dout_nxt_s  = usr_q;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Fill bits are combinational so the USR samples ser_in on the shift edge itself.
  assign usr_msb_in = mode_r & ~dir_r & ser_in;
  assign usr_lsb_in = mode_r & dir_r & ser_in;
  assign dout       = dout_r;

endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// Bench for usr_serdes_ctrl: two controllers (BIT_DIV 1 and 3), each driving a
// behavioural USR. Expected per-cycle outputs are queued when a transaction is
// launched and compared one entry per cycle; an empty queue means "expect idle".
module tb_usr_serdes_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, mode, dir, ser_in;
  logic [N-1:0] din;
  logic         start_r [2];
  logic [1:0]   s_w     [2];
  logic [N-1:0] i_w     [2];
  logic [N-1:0] q_r     [2];
  logic [N-1:0] dout_w  [2];
  logic         msb_w [2], lsb_w [2], so_w [2], busy_w [2], done_w [2];

  usr_serdes_ctrl #(.N(N), .BIT_DIV(1)) u_dut_d1 (
    .clk(clk), .reset(reset), .start(start_r[0]), .mode(mode), .dir(dir), .din(din),
    .ser_in(ser_in), .usr_q(q_r[0]), .usr_s(s_w[0]), .usr_I(i_w[0]),
    .usr_msb_in(msb_w[0]), .usr_lsb_in(lsb_w[0]), .ser_out(so_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .dout(dout_w[0])
  );

  usr_serdes_ctrl #(.N(N), .BIT_DIV(3)) u_dut_d3 (
    .clk(clk), .reset(reset), .start(start_r[1]), .mode(mode), .dir(dir), .din(din),
    .ser_in(ser_in), .usr_q(q_r[1]), .usr_s(s_w[1]), .usr_I(i_w[1]),
    .usr_msb_in(msb_w[1]), .usr_lsb_in(lsb_w[1]), .ser_out(so_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .dout(dout_w[1])
  );

  // Behavioural universal shift registers, reset_n tied to ~reset.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) q_r[d] <= {N{1'b0}};
      else begin
        case (s_w[d])
          2'b01:   q_r[d] <= {msb_w[d], q_r[d][N-1:1]};
          2'b10:   q_r[d] <= {q_r[d][N-2:0], lsb_w[d]};
          2'b11:   q_r[d] <= i_w[d];
          default: q_r[d] <= q_r[d];
        endcase
      end
    end
  end

  typedef struct packed {
    logic [1:0]   s;
    logic         so;
    logic         busy;
    logic         done;
    logic [N-1:0] i;
    logic [N-1:0] dout;
  } exp_t;

  exp_t         exp_q0 [$];
  exp_t         exp_q1 [$];
  logic [N-1:0] mdout [2];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic so, input logic b,
                              input logic dn, input logic [N-1:0] i, input logic [N-1:0] dv);
    exp_t e;
    e.s = s; e.so = so; e.busy = b; e.done = dn; e.i = i; e.dout = dv;
    return e;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Queue the full cycle-by-cycle expectation of one transaction plus its trailing IDLE cycle.
  task automatic predict(input int d, input int bd, input logic md, input logic dr,
                         input logic [N-1:0] word, input logic [N-1:0] rx);
    logic [N-1:0] res;
    push_exp(d, mk(2'b11, 1'b0, 1'b1, 1'b0, md ? {N{1'b0}} : word, mdout[d]));
    for (int b = 0; b < N; b++)
      for (int c = 0; c < bd; c++)
        push_exp(d, mk((c == bd - 1) ? (dr ? 2'b10 : 2'b01) : 2'b00,
                       md ? 1'b0 : (dr ? word[N-1-b] : word[b]),
                       1'b1, 1'b0, {N{1'b0}}, mdout[d]));
    push_exp(d, mk(2'b00, 1'b0, 1'b1, 1'b1, {N{1'b0}}, mdout[d]));
    res = {N{1'b0}};
    if (md)
      for (int k = 0; k < N; k++) begin
        if (dr) res[N-1-k] = rx[k];
        else    res[k]     = rx[k];
      end
    mdout[d] = res;
    push_exp(d, mk(2'b00, 1'b0, 1'b0, 1'b0, {N{1'b0}}, mdout[d]));
  endtask

  // Compare every cycle, #1 after the edge, against the queued (or idle) expectation.
  always @(posedge clk) begin
    exp_t e;
    logic have;
    #1;
    for (int d = 0; d < 2; d++) begin
      have = 1'b0;
      if (d == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front(); have = 1'b1;
      end else if (d == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front(); have = 1'b1;
      end
      if (!have) e = mk(2'b00, 1'b0, 1'b0, 1'b0, {N{1'b0}}, mdout[d]);
      check_val($sformatf("d%0d_usr_s", d),   32'(s_w[d]),    32'(e.s));
      check_val($sformatf("d%0d_ser_out", d), 32'(so_w[d]),   32'(e.so));
      check_val($sformatf("d%0d_busy", d),    32'(busy_w[d]), 32'(e.busy));
      check_val($sformatf("d%0d_done", d),    32'(done_w[d]), 32'(e.done));
      check_val($sformatf("d%0d_usr_I", d),   32'(i_w[d]),    32'(e.i));
      check_val($sformatf("d%0d_dout", d),    32'(dout_w[d]), 32'(e.dout));
    end
  end

  // One transaction; mode/dir/din are scrambled right after acceptance, optional ignored start pokes.
  task automatic run_txn(input int d, input int bd, input logic md, input logic dr,
                         input logic [N-1:0] word, input logic [N-1:0] rx, input bit poke);
    @(negedge clk);
    mode = md; dir = dr; din = word; start_r[d] = 1'b1;
    predict(d, bd, md, dr, word, rx);
    @(posedge clk); #1;
    start_r[d] = 1'b0; mode = ~md; dir = ~dr; din = ~word;
    @(posedge clk); #1;
    for (int b = 0; b < N; b++) begin
      ser_in     = rx[b];
      start_r[d] = poke && (b == 1);
      repeat (bd) begin
        @(posedge clk); #1;
        start_r[d] = 1'b0;
      end
    end
    start_r[d] = poke;
    ser_in     = 1'b0;
    @(posedge clk); #1;
    start_r[d] = 1'b0;
  endtask

  // Start held high across three transactions on the BIT_DIV=1 controller.
  task automatic run_b2b(input logic [N-1:0] word);
    @(negedge clk);
    mode = 1'b0; dir = 1'b0; din = word; ser_in = 1'b0; start_r[0] = 1'b1;
    repeat (3) predict(0, 1, 1'b0, 1'b0, word, {N{1'b0}});
    @(posedge clk);
    repeat (2 * (N + 3)) @(posedge clk);
    #1 start_r[0] = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
  endtask

  // Reset asserted during SHIFT once two bits have shifted on the BIT_DIV=1 controller.
  task automatic run_reset(input logic [N-1:0] word);
    @(negedge clk);
    mode = 1'b0; dir = 1'b0; din = word; start_r[0] = 1'b1;
    push_exp(0, mk(2'b11, 1'b0, 1'b1, 1'b0, word, mdout[0]));
    for (int b = 0; b < 3; b++)
      push_exp(0, mk(2'b01, word[b], 1'b1, 1'b0, {N{1'b0}}, mdout[0]));
    push_exp(0, mk(2'b00, 1'b0, 1'b0, 1'b0, {N{1'b0}}, {N{1'b0}}));
    mdout[0] = {N{1'b0}};
    @(posedge clk); #1 start_r[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_r[0] = 1'b0; start_r[1] = 1'b0;
    mode = 1'b0; dir = 1'b0; din = {N{1'b0}}; ser_in = 1'b0;
    mdout[0] = {N{1'b0}}; mdout[1] = {N{1'b0}};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    run_txn(0, 1, 1'b0, 1'b0, 4'b1011, N'($urandom), 1'b0);
    run_txn(0, 1, 1'b0, 1'b1, 4'b1011, N'($urandom), 1'b0);
    run_txn(0, 1, 1'b1, 1'b0, N'($urandom), 4'b0011, 1'b0);
    run_txn(0, 1, 1'b1, 1'b1, N'($urandom), 4'b0011, 1'b0);
    run_reset(4'b1101);
    run_txn(0, 1, 1'b0, 1'b0, 4'b0110, N'($urandom), 1'b1);
    run_b2b(4'b0101);
    for (int t = 0; t < 4; t++)
      run_txn(0, 1, 1'b1, 1'($urandom_range(0, 1)), N'($urandom), N'($urandom), 1'b0);
    run_txn(1, 3, 1'b0, 1'b0, 4'b0110, N'($urandom), 1'b0);
    run_txn(1, 3, 1'b0, 1'b1, 4'b1001, N'($urandom), 1'b1);
    run_txn(1, 3, 1'b1, 1'b0, N'($urandom), 4'b1010, 1'b0);
    run_txn(1, 3, 1'b1, 1'b1, N'($urandom), 4'b0001, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    check_val("queue_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
